// File: rtl/riscboy_ppu_pixel_agu_v2_pkg.sv
// Shared span types, pixel-size lookup and metadata layout for the PPU pixel AGU.
package riscboy_ppu_pixel_agu_v2_pkg;

  localparam int W_SPANTYPE = 3;

  typedef enum logic [W_SPANTYPE-1:0] {
    SPANTYPE_FILL  = 3'd0,
    SPANTYPE_BLIT  = 3'd1,
    SPANTYPE_TILE  = 3'd2,
    SPANTYPE_ABLIT = 3'd3,
    SPANTYPE_ATILE = 3'd4
  } spantype_t;

  localparam int W_PINFO_U = 4;
  localparam int W_PINFO   = W_PINFO_U + 2;

  typedef struct packed {
    logic                 reuse;
    logic                 discard;
    logic [W_PINFO_U-1:0] u;
  } pinfo_t;

  // pixmode 0: 16bpp, 1: 8bpp, 2: 4bpp, 3: 1bpp
  function automatic logic [2:0] mode_log_pixsize(input logic [1:0] pixmode);
    case (pixmode)
      2'd0:    return 3'd4;
      2'd1:    return 3'd3;
      2'd2:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscboy_ppu_pixel_agu_v2_if.sv
// Bus read port and pixel metadata port of the PPU pixel AGU.
interface riscboy_ppu_pixel_agu_v2_if #(
  parameter int W_ADDR = 18
);
  logic              bus_addr_vld;
  logic              bus_addr_rdy;
  logic [W_ADDR-1:0] bus_addr;
  logic              bus_data_vld;
  logic              bus_data_drop;
  logic [3:0]        pinfo_u;
  logic              pinfo_discard;
  logic              pinfo_reuse;
  logic              pinfo_vld;
  logic              pinfo_rdy;

  modport master (
    output bus_addr_vld, bus_addr, bus_data_drop,
    output pinfo_u, pinfo_discard, pinfo_reuse, pinfo_vld,
    input  bus_addr_rdy, bus_data_vld, pinfo_rdy
  );

  modport slave (
    input  bus_addr_vld, bus_addr, bus_data_drop,
    input  pinfo_u, pinfo_discard, pinfo_reuse, pinfo_vld,
    output bus_addr_rdy, bus_data_vld, pinfo_rdy
  );
endinterface

// File: rtl/riscboy_ppu_pixel_agu_v2_fifo.sv
// Small show-ahead FIFO for pixel metadata; push while full is legal when popping.
module riscboy_ppu_pixel_agu_v2_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int W_PTR = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [W_PTR:0]   wptr_reg;
  logic [W_PTR:0]   rptr_reg;
  logic [W_PTR:0]   level;

  assign level = wptr_reg - rptr_reg;
  assign full  = level == (W_PTR+1)'(DEPTH);
  assign empty = level == '0;
  assign rdata = mem[rptr_reg[W_PTR-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (flush) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + (W_PTR+1)'(1);
      if (pop)  rptr_reg <= rptr_reg + (W_PTR+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr_reg[W_PTR-1:0]] <= wdata;
  end
endmodule

// File: rtl/riscboy_ppu_pixel_agu_v2.sv
// PPU pixel address generator: blit/tile coords to aligned bus reads plus per-pixel metadata.
// Define RISCBOY_PPU_AGU_COALESCE_EN to skip refetching the last accepted bus word.
module riscboy_ppu_pixel_agu_v2
  import riscboy_ppu_pixel_agu_v2_pkg::*;
#(
  parameter int                W_COORD_SX  = 9,
  parameter int                W_COORD_UV  = 10,
  parameter int                W_SPAN_TYPE = 3,
  parameter int                W_ADDR      = 18,
  parameter int                W_BUS_DATA  = 16,
  parameter int                PINFO_DEPTH = 4,
  parameter logic [W_ADDR-1:0] ADDR_MASK   = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  riscboy_ppu_pixel_agu_v2_if.master bus,
  input  logic                   span_start,
  input  logic                   span_abort,
  input  logic [W_COORD_SX-1:0]  span_count,
  input  logic [W_SPAN_TYPE-1:0] span_type,
  input  logic [1:0]             span_pixmode,
  input  logic [W_ADDR-1:0]      span_texture_ptr,
  input  logic [2:0]             span_texsize,
  input  logic                   span_tilesize,
  input  logic                   span_ablit_halfsize,
  output logic                   span_done,
  input  logic [W_COORD_UV-1:0]  cgen_u,
  input  logic [W_COORD_UV-1:0]  cgen_v,
  input  logic                   cgen_vld,
  output logic                   cgen_rdy,
  input  logic [3:0]             tinfo_u,
  input  logic [3:0]             tinfo_v,
  input  logic [7:0]             tinfo_tilenum,
  input  logic                   tinfo_discard,
  input  logic                   tinfo_vld,
  output logic                   tinfo_rdy
);
  localparam int W_IDX      = (2 * W_COORD_UV > 16) ? 2 * W_COORD_UV : 16;
  localparam int W_BITOFF   = W_IDX + 4;
  localparam int W_ALIGN    = $clog2(W_BUS_DATA / 8);
  localparam int W_INFLIGHT = $clog2(PINFO_DEPTH) + 1;
  localparam logic [W_ADDR-1:0] ALIGN_MASK = ~W_ADDR'((1 << W_ALIGN) - 1);

  logic                   span_done_reg;
  logic [W_COORD_SX-1:0]  count_reg;
  logic [W_SPAN_TYPE-1:0] type_reg;
  logic [1:0]             pixmode_reg;
  logic [W_ADDR-1:0]      ptr_reg;
  logic [2:0]             texsize_reg;
  logic                   tilesize_reg;
  logic [W_INFLIGHT-1:0]  inflight_reg;
  logic [W_INFLIGHT-1:0]  drop_count_reg;

  logic                  is_tile, in_vld, pix_discard, oob, hit, active, issue, accept, addr_vld;
  logic [W_COORD_UV-1:0] mask;
  logic [W_IDX-1:0]      idx_blit, idx_tile, idx;
  logic [W_BITOFF-1:0]   bitoff;
  logic [W_ADDR-1:0]     addr_sum, pix_addr;
  logic                  fifo_full, fifo_empty, fifo_pop;
  pinfo_t                pinfo_wr, pinfo_rd;

  assign is_tile = (type_reg == W_SPAN_TYPE'(SPANTYPE_TILE)) || (type_reg == W_SPAN_TYPE'(SPANTYPE_ATILE));
  assign in_vld  = is_tile ? tinfo_vld : cgen_vld;

  // Blit texture is square, side 8<<texsize; coords outside it fetch nothing
  assign mask     = W_COORD_UV'((32'd8 << texsize_reg) - 32'd1);
  assign oob      = (|(cgen_u & ~mask)) || (|(cgen_v & ~mask));
  assign idx_blit = W_IDX'(cgen_u & mask) | (W_IDX'(cgen_v & mask) << ({1'b0, texsize_reg} + 4'd3));
  assign idx_tile = tilesize_reg ? W_IDX'({tinfo_tilenum, tinfo_v, tinfo_u})
                                 : W_IDX'({tinfo_tilenum, tinfo_v[2:0], tinfo_u[2:0]});
  assign idx      = is_tile ? idx_tile : idx_blit;
  assign bitoff   = W_BITOFF'(idx) << mode_log_pixsize(pixmode_reg);
  assign addr_sum = ptr_reg + W_ADDR'(bitoff >> 3);
  assign pix_addr = addr_sum & ALIGN_MASK & ADDR_MASK;

  assign pix_discard = is_tile ? tinfo_discard : oob;

`ifdef RISCBOY_PPU_AGU_COALESCE_EN
  logic              coal_vld_reg;
  logic [W_ADDR-1:0] coal_addr_reg;

  assign hit = coal_vld_reg && (coal_addr_reg == pix_addr) && !pix_discard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coal_vld_reg  <= 1'b0;
      coal_addr_reg <= '0;
    end else if (span_abort || span_start) begin
      coal_vld_reg  <= 1'b0;
    end else if (accept) begin
      coal_vld_reg  <= 1'b1;
      coal_addr_reg <= pix_addr;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Abort withdraws any unaccepted request in the same cycle
  assign fifo_pop = bus.pinfo_vld && bus.pinfo_rdy;
  assign active   = !span_done_reg && !span_abort && in_vld && (!fifo_full || fifo_pop);
  assign addr_vld = active && !pix_discard && !hit;
  assign accept   = addr_vld && bus.bus_addr_rdy;
  assign issue    = active && (pix_discard || hit || bus.bus_addr_rdy);

  assign bus.bus_addr_vld  = addr_vld;
  assign bus.bus_addr      = addr_vld ? pix_addr : '0;
  assign bus.bus_data_drop = bus.bus_data_vld && (drop_count_reg != '0);
  assign cgen_rdy  = issue && !is_tile;
  assign tinfo_rdy = issue && is_tile;
  assign span_done = span_done_reg;

  assign pinfo_wr = '{reuse: hit, discard: pix_discard, u: is_tile ? tinfo_u : cgen_u[3:0]};

  riscboy_ppu_pixel_agu_v2_fifo #(
    .WIDTH (W_PINFO),
    .DEPTH (PINFO_DEPTH)
  ) u_pinfo_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .wdata (pinfo_wr),
    .pop   (fifo_pop),
    .flush (span_abort),
    .rdata (pinfo_rd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.pinfo_vld     = !fifo_empty;
  assign bus.pinfo_u       = pinfo_rd.u;
  assign bus.pinfo_discard = pinfo_rd.discard;
  assign bus.pinfo_reuse   = pinfo_rd.reuse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      span_done_reg <= 1'b1;
      count_reg     <= '0;
      type_reg      <= '0;
      pixmode_reg   <= '0;
      ptr_reg       <= '0;
      texsize_reg   <= '0;
      tilesize_reg  <= 1'b0;
    end else if (span_abort) begin
      span_done_reg <= 1'b1;
    end else if (span_start) begin
      span_done_reg <= span_type == W_SPAN_TYPE'(SPANTYPE_FILL);
      count_reg     <= span_count;
      type_reg      <= span_type;
      pixmode_reg   <= span_pixmode;
      ptr_reg       <= span_texture_ptr;
      texsize_reg   <= (span_type == W_SPAN_TYPE'(SPANTYPE_ABLIT) && span_ablit_halfsize)
                       ? span_texsize - 3'd1 : span_texsize;
      tilesize_reg  <= span_tilesize;
    end else if (issue) begin
      if (count_reg == '0) span_done_reg <= 1'b1;
      else                 count_reg     <= count_reg - W_COORD_SX'(1);
    end
  end

  // All outstanding responses, old drops included, are discarded after an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg   <= '0;
      drop_count_reg <= '0;
    end else begin
      inflight_reg <= inflight_reg + W_INFLIGHT'(accept) - W_INFLIGHT'(bus.bus_data_vld);
      if (span_abort)
        drop_count_reg <= inflight_reg - W_INFLIGHT'(bus.bus_data_vld);
      else if (bus.bus_data_vld && drop_count_reg != '0)
        drop_count_reg <= drop_count_reg - W_INFLIGHT'(1);
    end
  end
endmodule

// File: tb/tb_riscboy_ppu_pixel_agu_v2.sv
// Scoreboard bench for the PPU pixel AGU: expected addresses and metadata queued at drive time.
module tb_riscboy_ppu_pixel_agu_v2;
  import riscboy_ppu_pixel_agu_v2_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscboy_ppu_pixel_agu_v2_if #(.W_ADDR(18)) bus_if ();

  logic        span_start, span_abort, span_tilesize, span_ablit_halfsize, span_done;
  logic [8:0]  span_count;
  logic [2:0]  span_type, span_texsize;
  logic [1:0]  span_pixmode;
  logic [17:0] span_texture_ptr;
  logic [9:0]  cgen_u, cgen_v;
  logic        cgen_vld, cgen_rdy;
  logic [3:0]  tinfo_u, tinfo_v;
  logic [7:0]  tinfo_tilenum;
  logic        tinfo_discard, tinfo_vld, tinfo_rdy;

  riscboy_ppu_pixel_agu_v2 dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .span_start(span_start), .span_abort(span_abort), .span_count(span_count),
    .span_type(span_type), .span_pixmode(span_pixmode), .span_texture_ptr(span_texture_ptr),
    .span_texsize(span_texsize), .span_tilesize(span_tilesize),
    .span_ablit_halfsize(span_ablit_halfsize), .span_done(span_done),
    .cgen_u(cgen_u), .cgen_v(cgen_v), .cgen_vld(cgen_vld), .cgen_rdy(cgen_rdy),
    .tinfo_u(tinfo_u), .tinfo_v(tinfo_v), .tinfo_tilenum(tinfo_tilenum),
    .tinfo_discard(tinfo_discard), .tinfo_vld(tinfo_vld), .tinfo_rdy(tinfo_rdy)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] addr_q [$];
  logic [5:0]  pinfo_q [$];
  int pend = 0, exp_drop = 0, acc_cnt = 0, drop_seen = 0, last_wait = 0;
  bit resp_hold = 1'b0;
  int m_type, m_pix, m_ptr, m_tex, m_tilesize, m_last;
  bit m_last_vld;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int bpp_of(input int pm);
    case (pm)
      0: return 16;
      1: return 8;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_oob(input int u, input int v);
    int side = 8 << m_tex;
    return (u >= side) || (v >= side);
  endfunction

  function automatic int model_addr(input bit tile, input int u, input int v, input int tn);
    int pix, side;
    if (tile) begin
      if (m_tilesize != 0) pix = tn * 256 + (v % 16) * 16 + (u % 16);
      else                 pix = tn * 64 + (v % 8) * 8 + (u % 8);
    end else begin
      side = 8 << m_tex;
      pix  = (u % side) + (v % side) * side;
    end
    return ((m_ptr + pix * bpp_of(m_pix) / 8) % (1 << 18)) & ~1;
  endfunction

  task automatic start_span(input int typ, input int pm, input int ptr, input int tex,
                            input int tsz, input int half, input int cnt);
    span_type = 3'(typ); span_pixmode = 2'(pm); span_texture_ptr = 18'(ptr);
    span_texsize = 3'(tex); span_tilesize = tsz[0]; span_ablit_halfsize = half[0];
    span_count = 9'(cnt); span_start = 1'b1;
    m_type = typ; m_pix = pm; m_ptr = ptr; m_tilesize = tsz; m_last_vld = 1'b0;
    m_tex = (typ == int'(SPANTYPE_ABLIT) && half != 0) ? ((tex - 1) & 7) : tex;
    @(posedge clk); #1;
    span_start = 1'b0;
  endtask

  task automatic push_pix(input bit tile, input int u, input int v, input int tn, input bit tdisc);
    bit disc, reuse;
    int a, n;
    disc  = tile ? tdisc : model_oob(u, v);
    a     = model_addr(tile, u, v, tn);
    reuse = 1'b0;
`ifdef RISCBOY_PPU_AGU_COALESCE_EN
    reuse = !disc && m_last_vld && (m_last == a);
`endif
    pinfo_q.push_back({reuse, disc, 4'(u)});
    if (!disc && !reuse) begin
      addr_q.push_back(a);
      m_last_vld = 1'b1;
      m_last     = a;
    end
    if (tile) begin
      tinfo_u = 4'(u); tinfo_v = 4'(v); tinfo_tilenum = 8'(tn); tinfo_discard = tdisc; tinfo_vld = 1'b1;
    end else begin
      cgen_u = 10'(u); cgen_v = 10'(v); cgen_vld = 1'b1;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (tile ? tinfo_rdy : cgen_rdy) break;
      n++;
      if (n >= 50) begin
        check_val("handshake_timeout", n, 0);
        break;
      end
    end
    last_wait = n;
    @(posedge clk); #1;
    cgen_vld = 1'b0; tinfo_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response generator: one response per cycle while any are pending
  initial begin
    bus_if.bus_data_vld = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus_if.bus_data_vld = (pend > 0) && !resp_hold;
    end
  end

  // Monitor: scoreboard pops and drop tracking
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int acc, resp;
        logic [31:0] e;
        acc  = int'(bus_if.bus_addr_vld && bus_if.bus_addr_rdy);
        resp = int'(bus_if.bus_data_vld);
        if (resp != 0) begin
          check_val("data_drop", bus_if.bus_data_drop, exp_drop != 0);
          if (bus_if.bus_data_drop) drop_seen++;
        end
        if (span_abort) exp_drop = pend - resp;
        else if (resp != 0 && exp_drop > 0) exp_drop--;
        pend = pend + acc - resp;
        if (acc != 0) begin
          acc_cnt++;
          $display("REQ   addr=%05h", bus_if.bus_addr);
          if (addr_q.size() > 0) begin
            e = addr_q.pop_front();
            check_val("bus_addr", bus_if.bus_addr, e);
          end else check_val("bus_unexpected", 1, 0);
        end
        if (bus_if.pinfo_vld && bus_if.pinfo_rdy) begin
          $display("PINFO reuse=%0b discard=%0b u=%0h", bus_if.pinfo_reuse, bus_if.pinfo_discard, bus_if.pinfo_u);
          if (pinfo_q.size() > 0) begin
            e = 32'(pinfo_q.pop_front());
            check_val("pinfo", {bus_if.pinfo_reuse, bus_if.pinfo_discard, bus_if.pinfo_u}, e);
          end else check_val("pinfo_unexpected", 1, 0);
        end
        if (span_abort) pinfo_q.delete();
      end
    end
  end

  initial begin
    int acc0, exp_a, exp_req;
    span_start = 0; span_abort = 0; span_count = 0; span_type = 0; span_pixmode = 0;
    span_texture_ptr = 0; span_texsize = 0; span_tilesize = 0; span_ablit_halfsize = 0;
    cgen_u = 0; cgen_v = 0; cgen_vld = 0; tinfo_u = 0; tinfo_v = 0; tinfo_tilenum = 0;
    tinfo_discard = 0; tinfo_vld = 0;
    bus_if.bus_addr_rdy = 1'b1; bus_if.pinfo_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_span_done", span_done, 1);
    check_val("rst_addr_vld", bus_if.bus_addr_vld, 0);
    check_val("rst_pinfo_vld", bus_if.pinfo_vld, 0);
    check_val("rst_drop", bus_if.bus_data_drop, 0);
    check_val("rst_cgen_rdy", cgen_rdy, 0);
    rst_n = 1'b1;
    idle(1);

    // 8bpp blit row on a 16-bit bus
    start_span(int'(SPANTYPE_BLIT), 1, 'h100, 0, 0, 0, 7);
    @(negedge clk); check_val("blit_not_done", span_done, 0); idle(1);
    for (int i = 0; i < 8; i++) push_pix(1'b0, i, 1, 0, 1'b0);
    @(negedge clk); check_val("blit_done", span_done, 1); idle(1);

    // Out-of-bounds blit pixel pops immediately with discard
    start_span(int'(SPANTYPE_BLIT), 1, 'h100, 0, 0, 0, 0);
    acc0 = acc_cnt;
    push_pix(1'b0, 8, 0, 0, 1'b0);
    check_val("oob_same_cycle", last_wait, 0);
    idle(3);
    check_val("oob_no_req", acc_cnt - acc0, 0);

    // 16px tile, 16bpp
    start_span(int'(SPANTYPE_TILE), 0, 0, 0, 1, 0, 0);
    push_pix(1'b1, 5, 3, 2, 1'b0);
    idle(2);
    // 8px tile plus a discarded tile pixel
    start_span(int'(SPANTYPE_ATILE), 1, 'h40, 0, 0, 0, 1);
    push_pix(1'b1, 2, 7, 1, 1'b0);
    push_pix(1'b1, 1, 0, 3, 1'b1);
    idle(2);
    // Half-size ABLIT shrinks texture to 8px
    start_span(int'(SPANTYPE_ABLIT), 1, 'h200, 1, 0, 1, 1);
    push_pix(1'b0, 9, 0, 0, 1'b0);
    push_pix(1'b0, 7, 7, 0, 1'b0);
    idle(2);

    // Bus stall: request held stable, nothing issued until accept
    start_span(int'(SPANTYPE_BLIT), 0, 'h20, 1, 0, 0, 0);
    exp_a = model_addr(1'b0, 3, 2, 0);
    acc0 = acc_cnt;
    bus_if.bus_addr_rdy = 1'b0;
    fork
      push_pix(1'b0, 3, 2, 0, 1'b0);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check_val("stall_vld", bus_if.bus_addr_vld, 1);
          check_val("stall_addr", bus_if.bus_addr, exp_a);
          check_val("stall_pinfo_vld", bus_if.pinfo_vld, 0);
        end
        @(posedge clk); #1;
        bus_if.bus_addr_rdy = 1'b1;
      end
    join
    idle(3);
    check_val("stall_one_req", acc_cnt - acc0, 1);
    check_val("stall_done", span_done, 1);

    // Full metadata FIFO blocks, then push with simultaneous pop
    start_span(int'(SPANTYPE_BLIT), 1, 0, 0, 0, 0, 4);
    bus_if.pinfo_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_pix(1'b0, 8 + i, 0, 0, 1'b0);
    fork
      push_pix(1'b0, 12, 0, 0, 1'b0);
      begin
        @(negedge clk);
        check_val("fifo_full_block", cgen_rdy, 0);
        @(posedge clk); #1;
        bus_if.pinfo_rdy = 1'b1;
      end
    join
    idle(6);
    check_val("fifo_span_done", span_done, 1);

    // Coalescing: four 4bpp pixels in one bus word
    start_span(int'(SPANTYPE_BLIT), 2, 0, 0, 0, 0, 3);
    acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) push_pix(1'b0, i, 0, 0, 1'b0);
    idle(3);
`ifdef RISCBOY_PPU_AGU_COALESCE_EN
    exp_req = 1;
`else
    exp_req = 4;
`endif
    check_val("coalesce_reqs", acc_cnt - acc0, exp_req);
    idle(8);

    // Abort with three responses in flight, new span during the drain
    resp_hold = 1'b1; bus_if.pinfo_rdy = 1'b0; drop_seen = 0;
    start_span(int'(SPANTYPE_BLIT), 0, 0, 0, 0, 0, 7);
    for (int i = 0; i < 3; i++) push_pix(1'b0, i, 0, 0, 1'b0);
    @(negedge clk); check_val("abort_pinfo_before", bus_if.pinfo_vld, 1); idle(1);
    span_abort = 1'b1;
    idle(1);
    span_abort = 1'b0;
    @(negedge clk);
    check_val("abort_fifo_empty", bus_if.pinfo_vld, 0);
    check_val("abort_done", span_done, 1);
    idle(1);
    bus_if.pinfo_rdy = 1'b1;
    start_span(int'(SPANTYPE_BLIT), 0, 'h300, 0, 0, 0, 0);
    push_pix(1'b0, 1, 1, 0, 1'b0);
    resp_hold = 1'b0;
    idle(10);
    check_val("abort_drops", drop_seen, 3);
    check_val("pend_drained", pend, 0);

    check_val("addr_q_left", addr_q.size(), 0);
    check_val("pinfo_q_left", pinfo_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
